gpio_mulpop: RTL and testbench
==============================

# gpio_mulpop

Bus-mapped, parametrised multiply/popcount coprocessor for the GPIO emulation platform. Software writes two operands over the simple `saddress`/`srd`/`swr` register bus, starts a job, and polls status. The block then multiplies by sequential shift-add, truncates the product to the result width, flags overflow and counts the set bits of the result serially. It also provides a latched GPIO input register and a start counter on `gpio_out`.

## Interface
- `DATA_W`, 24: operand width, 1..32; operands are taken from `sdata_in[DATA_W-1:0]`.
- `RES_W`, 32: result width, 1..32 and ≤ 2·`DATA_W`.
- `COUNT_W`, 16: start-counter width, 1..32.
- `BASE`, 16'h0380: register base address. Offsets: +0x00 A1, +0x08 A2, +0x10 W, +0x18 L, +0x20 CTRL/STATUS, +0x28 GPIN.
- `clk` in 1: clock; all state changes on the rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `saddress` in 16: register address.
- `srd` in 1: read strobe, level, synchronous to `clk`.
- `swr` in 1: write strobe, level, synchronous to `clk`.
- `sdata_in` in 32: write data.
- `sdata_out` out 32: registered read data.
- `gpio_in` in 32: external GPIO inputs.
- `gpio_latch` in 1: GPIO capture strobe, level, synchronous to `clk`.
- `gpio_out` out 32: `{zeros, start_cnt[COUNT_W-1:0]}`.
- `gpio_in_s_insp` out 32: latched GPIO value, for inspection.
- `irq` out 1: one-cycle pulse when a job completes.

## Operation
- **Strobe detection.** `srd`, `swr` and `gpio_latch` are registered each cycle. An access occurs only on the cycle where the strobe is 1 and its registered copy is 0. A held strobe therefore acts once.
- **Writes.**
  - A1 and A2: store `sdata_in[DATA_W-1:0]`. A write to either while busy is dropped and sets `err`.
  - CTRL:
    - bit0 = start.
    - bit1 = abort.
    - bit2 = 1 clears `err`.
    - If abort and start are written together, abort wins.
  - W, L, STATUS and GPIN are read-only. Writes to them, and to unmapped addresses, are ignored.
- **Reads.** `sdata_out` loads on the detect edge and holds until the next read.
  - A1 and A2 are zero-extended.
  - W returns `{0, W}`.
  - L returns `{0, L}`.
  - STATUS returns `{28'b0, err, valid, done, busy}`.
  - GPIN returns the latched value.
  - Unmapped addresses return 0.
- **FSM states.** IDLE, MULT, POPCNT, DONE.
- **Start.**
  - In IDLE: copies A1 and A2 into working registers, clears the accumulator, clears `done`, sets `busy`, increments `start_cnt` (wraps modulo 2^`COUNT_W`), then goes to MULT.
  - While busy: ignored, sets `err`, does not increment the counter.
- **MULT** runs `DATA_W` cycles.
  - Each cycle: if the working-A2 LSB is 1, add working A1 to the 2·`DATA_W`-bit accumulator.
  - Then shift working A1 left by one and working A2 right by one.
  - The sum never overflows the accumulator.
- **POPCNT** runs `RES_W` cycles.
  - Shift out `acc[RES_W-1:0]` one bit per cycle, LSB first.
  - Increment a 6-bit counter for each 1.
- **DONE** lasts one cycle, then returns to IDLE. On that cycle it commits:
  - W = `acc[RES_W-1:0]`.
  - L = the count.
  - `valid` = 1 if `acc[2·DATA_W-1:RES_W]` is zero (always 1 when `RES_W` = 2·`DATA_W`).
  - `done` = 1, `busy` = 0, `irq` = 1.
- **Result visibility.** W, L and `valid` keep their previous committed values until the next commit. Reading them during a job is legal.
- **Abort.** In MULT or POPCNT: go to IDLE, `busy` = 0, `done` = 0, no commit, no `irq`. In IDLE: no effect.
- **GPIO latch.** `gpio_in_s` captures `gpio_in` on the `gpio_latch` detect edge.

## Timing
- **Reset values.** All registers 0: `sdata_out`, `gpio_out`, `gpio_in_s_insp`, `irq`, status bits, W, L, A1, A2, `start_cnt`. State = IDLE.
- **Reset mid-job.** Aborts immediately, with no commit.
- **Job timeline.** Edge 0 samples the start write.
  - `busy` reads 1 from after edge 0.
  - MULT occupies edges 1..`DATA_W`.
  - POPCNT occupies edges `DATA_W`+1..`DATA_W`+`RES_W`.
  - Commit happens on edge `DATA_W`+`RES_W`+1: 57 for the defaults.
  - `irq` is high for exactly the cycle after the commit edge.
  - The next start is accepted on any edge after the commit.
- **Read latency.** `sdata_out` is valid one edge after the read detect. A STATUS read detected on the commit edge returns the pre-commit value (`busy` = 1).
- **Simultaneous events.**
  - Write and read detected on the same edge: the write takes effect, and the read returns the pre-write value.
  - `gpio_latch` and a GPIN read on the same edge: the read returns the old latched value.
  - Abort on the same edge the FSM would commit (DONE): the commit wins and the abort is ignored.

## Test plan
- **Basic multiply.** Reset, write A1=3, A2=5, start, poll STATUS. Required: `busy` for 57 cycles, then W=0x0000000F, L=4, STATUS=0x6, one `irq` pulse, `gpio_out`=1.
- **Overflow.** A1=A2=0xFFFFFF, start. Required: W=0xFE000001, L=8, `valid`=0, STATUS=0x2.
- **Start while busy.** Start, then at cycle 10 start again and write A1=7. Required: `err`=1, the first job's result is unchanged and committed at cycle 57, `gpio_out`=1. A CTRL write of 0x4 then clears `err`.
- **Abort.** Start, abort at cycle 20. Required: STATUS=0x0 next cycle, W and L keep their old values, no `irq`. A fresh job then completes normally.
- **Reset mid-job.** Deassert `n_reset` at cycle 30. Required: all outputs 0 asynchronously, IDLE after release.
- **Counter wrap and latch.** With `COUNT_W`=4, issue 16 completed starts. Required: `gpio_out` returns to 0. Then drive `gpio_in`=0xA5A5A5A5, pulse `gpio_latch` for 3 cycles. Required: `gpio_in_s_insp`=0xA5A5A5A5, and a GPIN read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/gpio_mulpop.sv
// Bus-mapped shift-add multiplier with serial popcount of the truncated product,
// plus a latched GPIO input register and a job-start counter on gpio_out.
module gpio_mulpop #(
  parameter int          DATA_W  = 24,
  parameter int          RES_W   = 32,
  parameter int          COUNT_W = 16,
  parameter logic [15:0] BASE    = 16'h0380
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp,
  output logic        irq
);
  // state  | meaning
  // IDLE   | waiting for a start write
  // MULT   | shift-add, one multiplier bit per cycle
  // POPCNT | count set bits of the truncated product, LSB first
  // DONE   | commit W/L/valid, pulse irq, return to IDLE
  localparam int          ACC_W     = 2 * DATA_W;
  localparam logic [15:0] ADDR_A1   = BASE;
  localparam logic [15:0] ADDR_A2   = BASE + 16'h0008;
  localparam logic [15:0] ADDR_W    = BASE + 16'h0010;
  localparam logic [15:0] ADDR_L    = BASE + 16'h0018;
  localparam logic [15:0] ADDR_CTRL = BASE + 16'h0020;
  localparam logic [15:0] ADDR_GPIN = BASE + 16'h0028;

  typedef enum logic [1:0] {IDLE, MULT, POPCNT, DONE} state_t;

  state_t             state;
  logic               srd_q, swr_q, latch_q;
  logic [DATA_W-1:0]  a1, a2, wa2;
  logic [ACC_W-1:0]   wa1, acc, acc_sum;
  logic [RES_W-1:0]   res_sh, w_reg;
  logic [5:0]         pop, l_reg, cnt;
  logic               valid, done, busy, err;
  logic [COUNT_W-1:0] start_cnt;
  logic [31:0]        gpio_in_s, rd_data;
  logic               rd_det, wr_det, latch_det, wr_ctrl, start_req, abort_req;
  logic               unused_sdata;

  assign rd_det         = srd & ~srd_q;
  assign wr_det         = swr & ~swr_q;
  assign latch_det      = gpio_latch & ~latch_q;
  assign wr_ctrl        = wr_det && (saddress == ADDR_CTRL);
  assign abort_req      = wr_ctrl & sdata_in[1];
  assign start_req      = wr_ctrl & sdata_in[0] & ~sdata_in[1];
  assign acc_sum        = wa2[0] ? acc + wa1 : acc;
  assign gpio_out       = 32'(start_cnt);
  assign gpio_in_s_insp = gpio_in_s;
  assign unused_sdata   = ^sdata_in;

  always_comb begin
    rd_data = '0;
    case (saddress)
      ADDR_A1:   rd_data = 32'(a1);
      ADDR_A2:   rd_data = 32'(a2);
      ADDR_W:    rd_data = 32'(w_reg);
      ADDR_L:    rd_data = 32'(l_reg);
      ADDR_CTRL: rd_data = {28'b0, err, valid, done, busy};
      ADDR_GPIN: rd_data = gpio_in_s;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      srd_q     <= 1'b0;
      swr_q     <= 1'b0;
      latch_q   <= 1'b0;
      a1        <= '0;
      a2        <= '0;
      wa1       <= '0;
      wa2       <= '0;
      acc       <= '0;
      res_sh    <= '0;
      w_reg     <= '0;
      pop       <= '0;
      l_reg     <= '0;
      cnt       <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      irq       <= 1'b0;
      start_cnt <= '0;
      gpio_in_s <= '0;
      sdata_out <= '0;
    end else begin
      srd_q   <= srd;
      swr_q   <= swr;
      latch_q <= gpio_latch;
      irq     <= 1'b0;

      if (latch_det) gpio_in_s <= gpio_in;
      if (rd_det)    sdata_out <= rd_data;

      // clear first so any error raised on the same edge still sticks
      if (wr_ctrl && sdata_in[2]) err <= 1'b0;
      if (wr_det && saddress == ADDR_A1) begin
        if (busy) err <= 1'b1;
        else      a1  <= sdata_in[DATA_W-1:0];
      end
      if (wr_det && saddress == ADDR_A2) begin
        if (busy) err <= 1'b1;
        else      a2  <= sdata_in[DATA_W-1:0];
      end
      if (start_req && state != IDLE) err <= 1'b1;

      case (state)
        IDLE: begin
          if (start_req) begin
            wa1       <= ACC_W'(a1);
            wa2       <= a2;
            acc       <= '0;
            pop       <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            start_cnt <= start_cnt + 1'b1;
            cnt       <= 6'(DATA_W - 1);
            state     <= MULT;
          end
        end
        MULT: begin
          if (abort_req) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_sum;
            wa1 <= wa1 << 1;
            wa2 <= wa2 >> 1;
            if (cnt == '0) begin
              res_sh <= acc_sum[RES_W-1:0];
              cnt    <= 6'(RES_W - 1);
              state  <= POPCNT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        POPCNT: begin
          if (abort_req) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            pop    <= pop + 6'(res_sh[0]);
            res_sh <= res_sh >> 1;
            if (cnt == '0) state <= DONE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        DONE: begin
          // an abort arriving here is ignored: the commit always completes
          w_reg <= acc[RES_W-1:0];
          l_reg <= pop;
          valid <= ((acc >> RES_W) == '0);
          done  <= 1'b1;
          busy  <= 1'b0;
          irq   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_mulpop.sv
// Randomized self-checking bench for gpio_mulpop against a product/popcount model.
module tb_gpio_mulpop;
  localparam logic [15:0] A_A1 = 16'h0380, A_A2 = 16'h0388, A_W = 16'h0390, A_L = 16'h0398;
  localparam logic [15:0] A_CTRL = 16'h03A0, A_GPIN = 16'h03A8, A_BAD = 16'h03B0;

  logic clk = 1'b0, n_reset = 1'b0;
  logic [15:0] saddress = '0;
  logic srd = 1'b0, swr = 1'b0, gpio_latch = 1'b0, irq;
  logic [31:0] sdata_in = '0, gpio_in = '0, sdata_out, gpio_out, gpio_in_s_insp;

  int errors = 0, checks = 0;

  logic [23:0] m_a1, m_a2, m_j1, m_j2;
  logic [31:0] m_w, m_gpin;
  logic [5:0]  m_l;
  logic        m_valid, m_done, m_err;
  int          m_cnt;

  gpio_mulpop #(.COUNT_W(4)) dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_a1 = '0; m_a2 = '0; m_j1 = '0; m_j2 = '0; m_w = '0; m_gpin = '0;
    m_l = '0; m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic model_start();
    m_j1 = m_a1; m_j2 = m_a2; m_done = 1'b0; m_cnt++;
  endtask

  task automatic model_commit();
    logic [63:0] p;
    p = 64'(m_j1) * 64'(m_j2);
    m_w     = p[31:0];
    m_l     = 6'($countones(p[31:0]));
    m_valid = (p[63:32] == 32'h0);
    m_done  = 1'b1;
  endtask

  function automatic logic [31:0] exp_status(input logic b);
    return {28'b0, m_err, m_valid, m_done, b};
  endfunction

  // all bus tasks start and end just after a falling edge
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(negedge clk); swr = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    saddress = a; srd = 1'b1;
    @(negedge clk); d = sdata_out; srd = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_edge0();
    saddress = A_CTRL; sdata_in = 32'h1; swr = 1'b1;
    @(negedge clk); swr = 1'b0;
    model_start();
  endtask

  task automatic watch_irq(input int k_from, output int first_k, output int n_hi);
    first_k = -1; n_hi = 0;
    for (int k = k_from; k <= 75; k++) begin
      @(negedge clk);
      if (irq) begin
        if (first_k < 0) first_k = k;
        n_hi++;
      end
    end
  endtask

  task automatic run_job(input logic [23:0] a, input logic [23:0] b, output int fk, output int nh);
    wr(A_A1, 32'(a)); m_a1 = a;
    wr(A_A2, 32'(b)); m_a2 = b;
    start_edge0();
    watch_irq(1, fk, nh);
    model_commit();
  endtask

  task automatic check_results(input string tag);
    logic [31:0] d;
    rd(A_CTRL, d);
    checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL %s_status: got %h want %h", tag, d, exp_status(1'b0)); end
    rd(A_W, d);
    checks++; if (d !== m_w) begin errors++; $display("FAIL %s_w: got %h want %h", tag, d, m_w); end
    rd(A_L, d);
    checks++; if (d !== 32'(m_l)) begin errors++; $display("FAIL %s_l: got %h want %h", tag, d, 32'(m_l)); end
    checks++; if (gpio_out !== 32'(m_cnt % 16)) begin errors++; $display("FAIL %s_gpio_out: got %h want %h", tag, gpio_out, 32'(m_cnt % 16)); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    model_reset();
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sdata_out !== 32'h0) begin errors++; $display("FAIL reset_sdata_out: got %h want 0", sdata_out); end
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio_out: got %h want 0", gpio_out); end
    checks++; if (gpio_in_s_insp !== 32'h0) begin errors++; $display("FAIL reset_gpin: got %h want 0", gpio_in_s_insp); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_reset = 1'b1;
    @(negedge clk);
    rd(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", d); end
    rd(A_A1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_a1: got %h want 0", d); end
  endtask

  task automatic test_basic();
    int fk, nh;
    run_job(24'd3, 24'd5, fk, nh);
    checks++; if (fk !== 57) begin errors++; $display("FAIL basic_irq_edge: got %0d want 57", fk); end
    checks++; if (nh !== 1) begin errors++; $display("FAIL basic_irq_width: got %0d want 1", nh); end
    checks++; if (m_w !== 32'hF || m_l !== 6'd4) begin errors++; $display("FAIL basic_model: got %h/%0d want f/4", m_w, m_l); end
    check_results("basic");
  endtask

  task automatic test_overflow();
    int fk, nh;
    run_job(24'hFFFFFF, 24'hFFFFFF, fk, nh);
    checks++; if (fk !== 57) begin errors++; $display("FAIL ovf_irq_edge: got %0d want 57", fk); end
    check_results("ovf");
  endtask

  task automatic test_random();
    int fk, nh;
    logic [23:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = 24'($urandom_range(0, 32'hFFFFFF) >> $urandom_range(0, 20));
      b = 24'($urandom_range(0, 32'hFFFFFF) >> $urandom_range(0, 20));
      run_job(a, b, fk, nh);
      checks++; if (fk !== 57 || nh !== 1) begin errors++; $display("FAIL rand_irq: got edge %0d x%0d want 57 x1", fk, nh); end
      check_results("rand");
    end
  endtask

  task automatic test_busy_start();
    int fk, nh;
    logic [31:0] d;
    wr(A_A1, 32'h000123); m_a1 = 24'h000123;
    wr(A_A2, 32'h00ABCD); m_a2 = 24'h00ABCD;
    start_edge0();
    repeat (9) @(negedge clk);
    wr(A_CTRL, 32'h1); m_err = 1'b1;
    wr(A_A1, 32'h7);
    watch_irq(14, fk, nh);
    model_commit();
    checks++; if (fk !== 57 || nh !== 1) begin errors++; $display("FAIL busy_irq: got edge %0d x%0d want 57 x1", fk, nh); end
    check_results("busy");
    rd(A_A1, d);
    checks++; if (d !== 32'(m_a1)) begin errors++; $display("FAIL busy_a1_dropped: got %h want %h", d, 32'(m_a1)); end
    wr(A_CTRL, 32'h4); m_err = 1'b0;
    rd(A_CTRL, d);
    checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL busy_err_clear: got %h want %h", d, exp_status(1'b0)); end
  endtask

  task automatic test_abort();
    int fk, nh;
    logic [31:0] d;
    wr(A_A1, 32'h00BEEF); m_a1 = 24'h00BEEF;
    wr(A_A2, 32'h001234); m_a2 = 24'h001234;
    start_edge0();
    repeat (19) @(negedge clk);
    wr(A_CTRL, 32'h2);
    rd(A_CTRL, d);
    checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL abort_status: got %h want %h", d, exp_status(1'b0)); end
    watch_irq(24, fk, nh);
    checks++; if (nh !== 0) begin errors++; $display("FAIL abort_irq: got %0d pulses want 0", nh); end
    rd(A_W, d);
    checks++; if (d !== m_w) begin errors++; $display("FAIL abort_w_kept: got %h want %h", d, m_w); end
    run_job(24'h00BEEF, 24'h001234, fk, nh);
    checks++; if (fk !== 57) begin errors++; $display("FAIL abort_rerun_edge: got %0d want 57", fk); end
    check_results("abort_rerun");
  endtask

  task automatic test_commit_edge();
    logic [31:0] d;
    wr(A_A1, 32'h000101); m_a1 = 24'h000101;
    wr(A_A2, 32'h000033); m_a2 = 24'h000033;
    start_edge0();
    repeat (56) @(negedge clk);
    saddress = A_CTRL; srd = 1'b1;
    @(negedge clk);
    checks++; if (sdata_out !== exp_status(1'b1)) begin errors++; $display("FAIL edge_read_status: got %h want %h", sdata_out, exp_status(1'b1)); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_read_irq: got %b want 1", irq); end
    srd = 1'b0;
    model_commit();
    @(negedge clk);
    check_results("edge_read");
    wr(A_A1, 32'h00F00F); m_a1 = 24'h00F00F;
    start_edge0();
    repeat (56) @(negedge clk);
    saddress = A_CTRL; sdata_in = 32'h2; swr = 1'b1;
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_abort_irq: got %b want 1", irq); end
    swr = 1'b0;
    model_commit();
    @(negedge clk);
    check_results("edge_abort");
  endtask

  task automatic test_simultaneous();
    logic [31:0] d, nv;
    nv = 32'($urandom_range(1, 32'hFFFFFF));
    saddress = A_A1; sdata_in = nv; swr = 1'b1; srd = 1'b1;
    @(negedge clk);
    checks++; if (sdata_out !== 32'(m_a1)) begin errors++; $display("FAIL simul_rw_old: got %h want %h", sdata_out, 32'(m_a1)); end
    swr = 1'b0; srd = 1'b0; m_a1 = nv[23:0];
    @(negedge clk);
    rd(A_A1, d);
    checks++; if (d !== 32'(m_a1)) begin errors++; $display("FAIL simul_rw_new: got %h want %h", d, 32'(m_a1)); end
    nv = $urandom;
    gpio_in = nv; gpio_latch = 1'b1; saddress = A_GPIN; srd = 1'b1;
    @(negedge clk);
    checks++; if (sdata_out !== m_gpin) begin errors++; $display("FAIL simul_gpin_old: got %h want %h", sdata_out, m_gpin); end
    gpio_latch = 1'b0; srd = 1'b0; m_gpin = nv;
    @(negedge clk);
    checks++; if (gpio_in_s_insp !== m_gpin) begin errors++; $display("FAIL simul_gpin_new: got %h want %h", gpio_in_s_insp, m_gpin); end
    wr(A_W, $urandom);
    wr(A_BAD, $urandom);
    rd(A_W, d);
    checks++; if (d !== m_w) begin errors++; $display("FAIL ro_w: got %h want %h", d, m_w); end
    rd(A_BAD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", d); end
  endtask

  task automatic test_reset_mid();
    int fk, nh;
    logic [31:0] d;
    wr(A_A2, 32'h00000F); m_a2 = 24'h00000F;
    start_edge0();
    repeat (30) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    checks++; if (sdata_out !== 32'h0 || gpio_out !== 32'h0 || gpio_in_s_insp !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got %h %h %h %b want all 0", sdata_out, gpio_out, gpio_in_s_insp, irq);
    end
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    @(negedge clk);
    rd(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h want 0", d); end
    run_job(24'h00ACE1, 24'h000777, fk, nh);
    checks++; if (fk !== 57 || nh !== 1) begin errors++; $display("FAIL midreset_job_irq: got edge %0d x%0d want 57 x1", fk, nh); end
    check_results("midreset");
  endtask

  task automatic test_wrap_latch();
    int fk, nh;
    logic [31:0] d;
    while (m_cnt < 16) begin
      run_job(24'($urandom_range(0, 32'hFFFFFF)), 24'($urandom_range(0, 32'hFFF)), fk, nh);
      checks++; if (gpio_out !== 32'(m_cnt % 16)) begin errors++; $display("FAIL wrap_count: got %h want %h", gpio_out, 32'(m_cnt % 16)); end
    end
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", gpio_out); end
    gpio_in = 32'hA5A5A5A5; gpio_latch = 1'b1;
    @(negedge clk);
    gpio_in = 32'h12345678;
    repeat (2) @(negedge clk);
    gpio_latch = 1'b0; m_gpin = 32'hA5A5A5A5;
    @(negedge clk);
    checks++; if (gpio_in_s_insp !== m_gpin) begin errors++; $display("FAIL latch_insp: got %h want %h", gpio_in_s_insp, m_gpin); end
    rd(A_GPIN, d);
    checks++; if (d !== m_gpin) begin errors++; $display("FAIL latch_read: got %h want %h", d, m_gpin); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_busy_start();
    test_abort();
    test_commit_edge();
    test_simultaneous();
    test_reset_mid();
    test_wrap_latch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
